// File: rtl/ram_scrubber.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_scrubber: walks the config RAM, rewrites words that differ from the  |
// | golden pattern. Option: SCRUB_AUTO_RESTART_EN (continuous passes).       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ram_scrubber #(
    parameter int                NUM_ADDRS = 4,
    parameter int                ADDR_W    = 4,
    parameter int                DATA_W    = 10,
    parameter logic [DATA_W-1:0] GOLD_EVEN = DATA_W'(10'h3FF),
    parameter logic [DATA_W-1:0] GOLD_ODD  = DATA_W'(10'h000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [7:0]        err_count_o,
    output logic [ADDR_W-1:0] last_err_addr_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_rd_enable_o,
    output logic              ram_wr_enable_o,
    output logic [DATA_W-1:0] ram_wr_data_o,
    input  logic [DATA_W-1:0] ram_rd_data_i
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ADDRS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CHK  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        err_q, err_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] gold;

    assign gold = addr_q[0] ? GOLD_ODD : GOLD_EVEN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            err_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        err_d   = err_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RD;
                    addr_d  = '0;
                    err_d   = '0;
                end
            end
            S_RD: state_d = S_CHK;
            S_CHK: begin
                if (ram_rd_data_i != gold) begin
                    state_d = S_WR;
                    err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
                    last_d  = addr_q;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RD;
                    addr_d  = addr_q + 1'b1;
                end
            end
            S_WR: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RD;
                    addr_d  = addr_q + 1'b1;
                end
            end
            S_DONE: begin
                addr_d = '0;
`ifdef SCRUB_AUTO_RESTART_EN
                // Continuous mode: error count keeps accumulating across passes
                state_d = S_RD;
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes decode straight from state so reset drops them immediately
    always_comb begin
        busy_o          = (state_q != S_IDLE);
        done_o          = (state_q == S_DONE);
        ram_rd_enable_o = (state_q == S_RD);
        ram_wr_enable_o = (state_q == S_WR);
        ram_wr_data_o   = (state_q == S_WR) ? gold : '0;
        ram_addr_o      = addr_q;
        err_count_o     = err_q;
        last_err_addr_o = last_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_scrubber.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ram_scrubber: self-checking bench with RAM model and pass model.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ram_scrubber;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, rd_en, wr_en;
    logic [7:0] err_count;
    logic [3:0] last_err_addr, ram_addr;
    logic [9:0] wr_data;
    logic [9:0] rd_data = 10'h0;

    int checks = 0;
    int errors = 0;
    int model_last = 0;

    always #5 clk = ~clk;

    ram_scrubber dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start),
        .busy_o          (busy),
        .done_o          (done),
        .err_count_o     (err_count),
        .last_err_addr_o (last_err_addr),
        .ram_addr_o      (ram_addr),
        .ram_rd_enable_o (rd_en),
        .ram_wr_enable_o (wr_en),
        .ram_wr_data_o   (wr_data),
        .ram_rd_data_i   (rd_data)
    );

    // RAM model: registered read, synchronous write
    logic [9:0] mem     [N];
    logic [9:0] pre_mem [N];
    logic       load = 1'b0;
    logic       force155 = 1'b0;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < N; i++) mem[i] <= pre_mem[i];
        end else if (wr_en && int'(ram_addr) < N) begin
            mem[ram_addr[1:0]] <= wr_data;
        end
        if (rd_en) rd_data <= force155 ? 10'h155 : ((int'(ram_addr) < N) ? mem[ram_addr[1:0]] : 10'h2AA);
    end

    int         rd_log[$];
    int         wr_addr_log[$];
    logic [9:0] wr_data_log[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en) rd_log.push_back(int'(ram_addr));
            if (wr_en) begin
                wr_addr_log.push_back(int'(ram_addr));
                wr_data_log.push_back(wr_data);
            end
            checks++;
            if (rd_en && wr_en) begin
                errors++;
                $display("FAIL strobe_overlap: rd=%0b wr=%0b required not both 1", rd_en, wr_en);
            end
            checks++;
            if (!wr_en && wr_data != 10'h0) begin
                errors++;
                $display("FAIL wr_data_idle: got %h required 000", wr_data);
            end
        end
    end

    function automatic logic [9:0] gold(input int a);
        return (a % 2 == 1) ? 10'h000 : 10'h3FF;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic load_ram(input logic [N-1:0][9:0] p);
        @(negedge clk);
        for (int i = 0; i < N; i++) pre_mem[i] = p[i];
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
    endtask

    task automatic run_pass(input logic [N-1:0][9:0] p, input int exp_err,
                            input int exp_last, input int exp_lat, input string tag);
        int cyc;
        bit got_done;
        int exp_wa[$];
        load_ram(p);
        for (int i = 0; i < N; i++) if (p[i] != gold(i)) exp_wa.push_back(i);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk({tag, "_busy_first"}, int'(busy), 1);
            if (done) got_done = 1'b1;
        end
        chk({tag, "_done_latency"}, cyc, exp_lat);
        chk({tag, "_err_count"}, int'(err_count), exp_err);
        chk({tag, "_last_err_addr"}, int'(last_err_addr), exp_last);
        chk({tag, "_num_reads"}, rd_log.size(), N);
        for (int i = 0; i < N && i < rd_log.size(); i++) chk({tag, "_read_addr"}, rd_log[i], i);
        chk({tag, "_num_writes"}, wr_addr_log.size(), exp_wa.size());
        for (int i = 0; i < exp_wa.size() && i < wr_addr_log.size(); i++) begin
            chk({tag, "_write_addr"}, wr_addr_log[i], exp_wa[i]);
            chk({tag, "_write_data"}, int'(wr_data_log[i]), int'(gold(exp_wa[i])));
        end
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, int'(done), 0);
        chk({tag, "_busy_after"}, int'(busy), 0);
        chk({tag, "_addr_after"}, int'(ram_addr), 0);
        for (int i = 0; i < N; i++) chk({tag, "_ram_scrubbed"}, int'(mem[i]), int'(gold(i)));
    endtask

    typedef struct {
        logic [N-1:0][9:0] pre;
        int                exp_err;
        int                exp_last;
        int                exp_lat;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [N-1:0][9:0] p;
        int e;
        int cyc;
        int dones;
        int done_cyc;
        bit hit;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err_count), 0);
        chk("rst_last", int'(last_err_addr), 0);
        chk("rst_addr", int'(ram_addr), 0);
        chk("rst_strobes", int'({rd_en, wr_en}), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        rst_n = 1'b1;

`ifdef SCRUB_AUTO_RESTART_EN
        force155 = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int pass = 1; pass <= 66; pass++) begin
            cyc = 0;
            hit = 1'b0;
            while (!hit && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (!busy) chk("auto_busy", int'(busy), 1);
                if (done) hit = 1'b1;
            end
            chk("auto_pass_len", cyc, (pass == 1) ? 1 + 3 * N : 1 + 3 * N);
            chk("auto_err_count", int'(err_count), (4 * pass > 255) ? 255 : 4 * pass);
        end
        chk("auto_busy_end", int'(busy), 1);
`else
        vecs[0].pre = {10'h000, 10'h3FF, 10'h000, 10'h3FF};
        vecs[0].exp_err = 0; vecs[0].exp_last = 0; vecs[0].exp_lat = 9;
        vecs[1].pre = {10'h000, 10'h155, 10'h000, 10'h3FF};
        vecs[1].exp_err = 1; vecs[1].exp_last = 2; vecs[1].exp_lat = 10;
        vecs[2].pre = {10'h000, 10'h3FF, 10'h000, 10'h3FF};
        vecs[2].exp_err = 0; vecs[2].exp_last = 2; vecs[2].exp_lat = 9;
        vecs[3].pre = {10'h3FF, 10'h000, 10'h3FF, 10'h000};
        vecs[3].exp_err = 4; vecs[3].exp_last = 3; vecs[3].exp_lat = 13;
        for (int v = 0; v < 4; v++)
            run_pass(vecs[v].pre, vecs[v].exp_err, vecs[v].exp_last, vecs[v].exp_lat, $sformatf("vec%0d", v));
        model_last = 3;

        // Random passes against the pass-level model
        for (int r = 0; r < 20; r++) begin
            e = 0;
            for (int i = 0; i < N; i++) begin
                p[i] = ($urandom_range(0, 1) == 1) ? gold(i) : 10'($urandom);
                if (p[i] != gold(i)) begin
                    e++;
                    model_last = i;
                end
            end
            run_pass(p, e, model_last, 1 + 2 * N + e, $sformatf("rand%0d", r));
        end

        // start pulses during a busy pass are ignored
        load_ram({10'h000, 10'h3FF, 10'h000, 10'h3FF});
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dones = 0;
        done_cyc = 0;
        for (cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            start = (cyc == 2 || cyc == 4);
        end
        start = 1'b0;
        chk("busy_start_done_count", dones, 1);
        chk("busy_start_done_cycle", done_cyc, 9);
        chk("busy_start_idle", int'(busy), 0);
        run_pass({10'h000, 10'h3FF, 10'h000, 10'h3FF}, 0, model_last, 9, "after_ignored");

        // Reset during the write of address 1
        load_ram({10'h000, 10'h3FF, 10'h3FF, 10'h3FF});
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        hit = 1'b0;
        for (cyc = 0; cyc < 30 && !hit; cyc++) begin
            @(negedge clk);
            if (wr_en && ram_addr == 4'd1) hit = 1'b1;
        end
        chk("rstwr_reached_wr", int'(hit), 1);
        rst_n = 1'b0;
        #1;
        chk("rstwr_wr_en", int'(wr_en), 0);
        chk("rstwr_busy", int'(busy), 0);
        chk("rstwr_err", int'(err_count), 0);
        chk("rstwr_last", int'(last_err_addr), 0);
        chk("rstwr_addr", int'(ram_addr), 0);
        @(posedge clk);
        #1;
        chk("rstwr_no_write", int'(mem[1]), 10'h3FF);
        @(negedge clk);
        rst_n = 1'b1;
        rd_log.delete();
        repeat (5) @(negedge clk);
        chk("rstwr_idle_busy", int'(busy), 0);
        chk("rstwr_idle_reads", rd_log.size(), 0);
        run_pass({10'h000, 10'h3FF, 10'h3FF, 10'h3FF}, 1, 1, 10, "after_reset");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
